mod_sampler: RTL and testbench

//   Modulation index generator; consumes the modulation register block (AddrModCycle*,

---
 rtl/mod_sampler.sv | 136 +++++++++++++
 tb/tb_mod_sampler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sampler.sv
// mod_sampler: modulation sample-index generator with finite/infinite repeat
// and double-buffered segment swap. Optional debug port DBG_LOOP_CNT is
// enabled by defining MOD_SAMPLER_LOOP_CNT_EN.
module mod_sampler #(
    parameter int unsigned IdxWidth = 15,
    parameter int unsigned DivWidth = 16,
    parameter int unsigned RepWidth = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                TICK,
    input  logic                SET,
    input  logic                REQ_RD_SEGMENT,
    input  logic [IdxWidth-1:0] CYCLE0,
    input  logic [IdxWidth-1:0] CYCLE1,
    input  logic [DivWidth-1:0] FREQ_DIV0,
    input  logic [DivWidth-1:0] FREQ_DIV1,
    input  logic [RepWidth-1:0] REP0,
    input  logic [RepWidth-1:0] REP1,
`ifdef MOD_SAMPLER_LOOP_CNT_EN
    output logic [RepWidth-1:0] DBG_LOOP_CNT,
`endif
    output logic [IdxWidth-1:0] IDX,
    output logic                SEGMENT,
    output logic                STOP,
    output logic                SWAP_PENDING
);

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } state_t;

    state_t              state;
    logic [IdxWidth-1:0] cyc_sh0, cyc_sh1;
    logic [DivWidth-1:0] div_sh0, div_sh1;
    logic [RepWidth-1:0] rep_sh0, rep_sh1;
    logic [DivWidth-1:0] div_cnt;
    logic [RepWidth-1:0] loop_cnt;

    logic [IdxWidth-1:0] cyc_act;
    logic [DivWidth-1:0] div_act;
    logic [RepWidth-1:0] rep_act;
    logic [DivWidth-1:0] div_lim;
    logic                rep_inf;
    logic                req_rep_inf;
    logic                req_other;
    logic                imm_swap;

    // Active-segment shadow selection and swap qualification
    always_comb begin
        cyc_act     = SEGMENT ? cyc_sh1 : cyc_sh0;
        div_act     = SEGMENT ? div_sh1 : div_sh0;
        rep_act     = SEGMENT ? rep_sh1 : rep_sh0;
        div_lim     = (div_act == '0) ? '0 : DivWidth'(div_act - DivWidth'(1));
        rep_inf     = &rep_act;
        req_rep_inf = REQ_RD_SEGMENT ? (&REP1) : (&REP0);
        req_other   = (REQ_RD_SEGMENT != SEGMENT);
        imm_swap    = SET && req_other && (req_rep_inf || (state == STOPPED));
    end

    // Shadow registers, divider, index stepping, repeat and swap control
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= RUN;
            IDX          <= '0;
            SEGMENT      <= 1'b0;
            STOP         <= 1'b0;
            SWAP_PENDING <= 1'b0;
            div_cnt      <= '0;
            loop_cnt     <= '0;
            cyc_sh0      <= '0;
            cyc_sh1      <= '0;
            div_sh0      <= DivWidth'(1);
            div_sh1      <= DivWidth'(1);
            rep_sh0      <= '1;
            rep_sh1      <= '1;
        end else begin
            if (SET) begin
                cyc_sh0 <= CYCLE0;
                cyc_sh1 <= CYCLE1;
                div_sh0 <= FREQ_DIV0;
                div_sh1 <= FREQ_DIV1;
                rep_sh0 <= REP0;
                rep_sh1 <= REP1;
            end

            if (imm_swap) begin
                // Immediate swap wins over any TICK in the same cycle
                state        <= RUN;
                SEGMENT      <= ~SEGMENT;
                IDX          <= '0;
                div_cnt      <= '0;
                loop_cnt     <= '0;
                STOP         <= 1'b0;
                SWAP_PENDING <= 1'b0;
            end else begin
                if ((state == RUN) && TICK) begin
                    if (div_cnt >= div_lim) begin
                        div_cnt <= '0;
                        if (IDX >= cyc_act) begin
                            if (SWAP_PENDING) begin
                                SEGMENT      <= ~SEGMENT;
                                IDX          <= '0;
                                loop_cnt     <= '0;
                                SWAP_PENDING <= 1'b0;
                            end else if (!rep_inf && (loop_cnt == rep_act)) begin
                                state <= STOPPED;
                                STOP  <= 1'b1;
                            end else begin
                                IDX <= '0;
                                if (!(&loop_cnt)) begin
                                    loop_cnt <= RepWidth'(loop_cnt + RepWidth'(1));
                                end
                            end
                        end else begin
                            IDX <= IdxWidth'(IDX + IdxWidth'(1));
                        end
                    end else begin
                        div_cnt <= DivWidth'(div_cnt + DivWidth'(1));
                    end
                end
                // Latest SET decides the pending request (same segment cancels)
                if (SET) begin
                    SWAP_PENDING <= req_other;
                end
            end
        end
    end

`ifdef MOD_SAMPLER_LOOP_CNT_EN
    // Debug view of the completed-loop counter
    always_comb DBG_LOOP_CNT = loop_cnt;
`endif

endmodule

// File: tb/tb_mod_sampler.sv
// Self-checking bench for mod_sampler: directed scenarios with fixed expected
// values plus a randomized run against a behavioural model.
module tb_mod_sampler;
    localparam int unsigned IW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 16;
    localparam int INF = 65535;

    logic          clk = 1'b0;
    logic          rst_n, tick, set, req;
    logic [IW-1:0] c0, c1;
    logic [DW-1:0] d0, d1;
    logic [RW-1:0] r0, r1;
    logic [IW-1:0] idx;
    logic          seg, stop, pend;
`ifdef MOD_SAMPLER_LOOP_CNT_EN
    logic [RW-1:0] dbg;
`endif

    always #5 clk = ~clk;

    mod_sampler dut (
        .CLK(clk), .RST_N(rst_n), .TICK(tick), .SET(set), .REQ_RD_SEGMENT(req),
        .CYCLE0(c0), .CYCLE1(c1), .FREQ_DIV0(d0), .FREQ_DIV1(d1), .REP0(r0), .REP1(r1),
`ifdef MOD_SAMPLER_LOOP_CNT_EN
        .DBG_LOOP_CNT(dbg),
`endif
        .IDX(idx), .SEGMENT(seg), .STOP(stop), .SWAP_PENDING(pend)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_idx, m_seg, m_stop, m_pend, m_div, m_loop;
    int sh_cyc[2];
    int sh_div[2];
    int sh_rep[2];

    function automatic void model_reset();
        m_idx = 0; m_seg = 0; m_stop = 0; m_pend = 0; m_div = 0; m_loop = 0;
        sh_cyc[0] = 0;   sh_cyc[1] = 0;
        sh_div[0] = 1;   sh_div[1] = 1;
        sh_rep[0] = INF; sh_rep[1] = INF;
    endfunction

    function automatic void model_clock();
        int old_seg, div_eff, req_rep;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_seg = m_seg;
        req_rep = req ? int'(r1) : int'(r0);
        div_eff = (sh_div[old_seg] == 0) ? 1 : sh_div[old_seg];
        if (set && int'(req) != old_seg && (req_rep == INF || m_stop == 1)) begin
            m_seg = 1 - old_seg; m_idx = 0; m_div = 0; m_loop = 0; m_stop = 0; m_pend = 0;
        end else begin
            if (tick && m_stop == 0) begin
                m_div = m_div + 1;
                if (m_div >= div_eff) begin
                    m_div = 0;
                    if (m_idx < sh_cyc[old_seg]) m_idx = m_idx + 1;
                    else if (m_pend == 1) begin
                        m_seg = 1 - old_seg; m_idx = 0; m_loop = 0; m_pend = 0;
                    end else if (sh_rep[old_seg] != INF && m_loop == sh_rep[old_seg]) m_stop = 1;
                    else begin
                        m_idx = 0;
                        if (m_loop < INF) m_loop = m_loop + 1;
                    end
                end
            end
            if (set) m_pend = (int'(req) != old_seg) ? 1 : 0;
        end
        if (set) begin
            sh_cyc[0] = int'(c0); sh_cyc[1] = int'(c1);
            sh_div[0] = int'(d0); sh_div[1] = int'(d1);
            sh_rep[0] = int'(r0); sh_rep[1] = int'(r1);
        end
    endfunction

    function automatic logic [IW+2:0] exp_vec();
        logic [IW+2:0] v;
        v = {IW'(m_idx), m_seg[0], m_stop[0], m_pend[0]};
        return v;
    endfunction

    task automatic step(input logic t, input logic s);
        tick = t; set = s;
        @(posedge clk);
        model_clock();
        #1;
        tick = 1'b0; set = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if ({idx, seg, stop, pend} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got idx=%0d seg=%0b stop=%0b pend=%0b, want all 0", idx, seg, stop, pend);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_div_inf();
        do_reset();
        req = 0; c0 = 3; d0 = 2; r0 = RW'(INF);
        step(1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (idx !== IW'((k / 2) % 4) || stop !== 1'b0) begin
                n_fail++;
                $display("FAIL div_inf tick %0d: got idx=%0d stop=%0b, want idx=%0d stop=0", k, idx, stop, (k / 2) % 4);
            end
        end
    endtask

    task automatic test_finite_stop();
        int exp_idx[7] = '{1, 0, 1, 1, 1, 1, 1};
        int exp_stp[7] = '{0, 0, 0, 1, 1, 1, 1};
        do_reset();
        req = 0; c0 = 1; d0 = 1; r0 = 1;
        step(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (idx !== IW'(exp_idx[k]) || stop !== exp_stp[k][0]) begin
                n_fail++;
                $display("FAIL finite_stop tick %0d: got idx=%0d stop=%0b, want idx=%0d stop=%0d", k, idx, stop, exp_idx[k], exp_stp[k]);
            end
        end
        // SET to the current segment keeps STOPPED
        step(1'b1, 1'b1);
        n_checks++;
        if (stop !== 1'b1 || idx !== IW'(1) || seg !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_same_set: got idx=%0d seg=%0b stop=%0b, want idx=1 seg=0 stop=1", idx, seg, stop);
        end
        // SET to the other segment leaves STOPPED even with finite repeat
        req = 1; c1 = 2; d1 = 1; r1 = 2;
        step(1'b0, 1'b1);
        n_checks++;
        if ({idx, seg, stop, pend} !== {IW'(0), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_swap: got idx=%0d seg=%0b stop=%0b pend=%0b, want idx=0 seg=1 stop=0 pend=0", idx, seg, stop, pend);
        end
    endtask

    task automatic test_pending_swap();
        do_reset();
        req = 0; c0 = 4; d0 = 1; r0 = 3; c1 = 5; d1 = 1; r1 = 2;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        req = 1;
        step(1'b0, 1'b1);
        n_checks++;
        if ({idx, seg, pend} !== {IW'(2), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pending_set: got idx=%0d seg=%0b pend=%0b, want idx=2 seg=0 pend=1", idx, seg, pend);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if ({idx, seg, pend} !== {IW'(4), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pending_wait: got idx=%0d seg=%0b pend=%0b, want idx=4 seg=0 pend=1", idx, seg, pend);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if ({idx, seg, pend} !== {IW'(0), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pending_swap: got idx=%0d seg=%0b pend=%0b, want idx=0 seg=1 pend=0", idx, seg, pend);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (idx !== IW'(1) || seg !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_after: got idx=%0d seg=%0b, want idx=1 seg=1", idx, seg);
        end
    endtask

    task automatic test_immediate_swap();
        do_reset();
        req = 0; c0 = 4; d0 = 1; r0 = RW'(INF); c1 = 3; d1 = 1; r1 = RW'(INF);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        req = 1;
        step(1'b1, 1'b1);
        n_checks++;
        if ({idx, seg, stop, pend} !== {IW'(0), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL immediate_swap: got idx=%0d seg=%0b stop=%0b pend=%0b, want idx=0 seg=1 stop=0 pend=0", idx, seg, stop, pend);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (idx !== IW'(1)) begin
            n_fail++;
            $display("FAIL immediate_after: got idx=%0d, want 1", idx);
        end
    endtask

    task automatic test_div0_shrink();
        do_reset();
        req = 0; c0 = 7; d0 = 0; r0 = RW'(INF);
        step(1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (idx !== IW'(k)) begin
                n_fail++;
                $display("FAIL div0 tick %0d: got idx=%0d, want %0d", k, idx, k);
            end
        end
        c0 = 2;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_checks++;
        if (idx !== IW'(0) || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL shrink_wrap: got idx=%0d stop=%0b, want idx=0 stop=0", idx, stop);
        end
`ifdef MOD_SAMPLER_LOOP_CNT_EN
        n_checks++;
        if (dbg !== RW'(1)) begin
            n_fail++;
            $display("FAIL shrink_loop_cnt: got %0d, want 1", dbg);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 0; c0 = 4; d0 = 1; r0 = 3; c1 = 5; d1 = 1; r1 = 2;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        req = 1;
        step(1'b0, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        n_checks++;
        if ({idx, seg, stop, pend} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got idx=%0d seg=%0b stop=%0b pend=%0b, want all 0", idx, seg, stop, pend);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        n_checks++;
        if ({idx, seg, stop, pend} !== '0) begin
            n_fail++;
            $display("FAIL reset_defaults: got idx=%0d seg=%0b stop=%0b pend=%0b, want all 0", idx, seg, stop, pend);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) begin
                req = $urandom_range(0, 1);
                c0 = IW'($urandom_range(0, 5)); c1 = IW'($urandom_range(0, 5));
                d0 = DW'($urandom_range(0, 3)); d1 = DW'($urandom_range(0, 3));
                r0 = ($urandom_range(0, 3) == 0) ? RW'(INF) : RW'($urandom_range(0, 2));
                r1 = ($urandom_range(0, 3) == 0) ? RW'(INF) : RW'($urandom_range(0, 2));
                step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                step(1'($urandom_range(0, 2) != 0), 1'b0);
            end
            n_checks++;
            if ({idx, seg, stop, pend} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got idx=%0d seg=%0b stop=%0b pend=%0b, want idx=%0d seg=%0d stop=%0d pend=%0d",
                         n, idx, seg, stop, pend, m_idx, m_seg, m_stop, m_pend);
            end
`ifdef MOD_SAMPLER_LOOP_CNT_EN
            n_checks++;
            if (dbg !== RW'(m_loop)) begin
                n_fail++;
                $display("FAIL random_loop_cnt cycle %0d: got %0d, want %0d", n, dbg, m_loop);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; set = 1'b0; req = 1'b0;
        c0 = '0; c1 = '0; d0 = '0; d1 = '0; r0 = '0; r1 = '0;
        model_reset();
        test_reset();
        test_div_inf();
        test_finite_stop();
        test_pending_swap();
        test_immediate_swap();
        test_div0_shrink();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
